trace_replayer: RTL and testbench

TRACE_REPLAYER -- requirements
Module: trace_replayer

---
 rtl/trace_replayer_pkg.sv | 13 +
 rtl/trace_replayer_fifo.sv | 70 +++++++
 rtl/trace_replayer.sv | 97 +++++++++
 tb/tb_trace_replayer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_replayer_pkg.sv
// Shared definitions for the trace replayer: FSM state encoding and access-kind constants.
package trace_replayer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic KIND_INSTR = 1'b0;
  localparam logic KIND_DATA  = 1'b1;

endpackage

// File: rtl/trace_replayer_fifo.sv
// Trace storage: circular buffer of (address, kind) entries with wrapping pointers
// and an occupancy count that tells full (DEPTH) apart from empty (0).
module trace_fifo
  import trace_replayer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              push_kind_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic              head_kind_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DEPTH-1:0]  kind_mem_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage is never reset; only the pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      kind_mem_q[wr_ptr_q] <= push_kind_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_kind_o = kind_mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/trace_replayer.sv
// Trace replayer top: records (address, kind) accesses while idle, then replays them
// in FIFO order as a valid/ready request stream and signals completion.
module trace_replayer
  import trace_replayer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_valid_i,
  input  logic [ADDR_W-1:0]        load_addr_i,
  input  logic                     load_kind_i,
  output logic                     load_ready_o,
  input  logic                     start_i,
  output logic                     req_valid_o,
  output logic [ADDR_W-1:0]        req_addr_o,
  output logic                     req_kind_o,
  input  logic                     req_ready_i,
  output logic                     done_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e state_q, state_d;
  logic   req_valid_q, req_valid_d;
  logic   done_q, done_d;

  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic              head_kind;

  assign load_ready_o = (state_q == IDLE) && (count_o < CNT_W'(DEPTH));
  assign push         = load_valid_i && load_ready_o;
  assign pop          = req_valid_q && req_ready_i;

  trace_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_addr_i (load_addr_i),
    .push_kind_i (load_kind_i),
    .pop_i       (pop),
    .head_addr_o (head_addr),
    .head_kind_o (head_kind),
    .count_o     (count_o)
  );

  // A load accepted in the start cycle counts toward the IDLE->PLAY decision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ((count_o != '0) || push) ? PLAY : DONE;
        end
      end
      PLAY: begin
        if ((count_o == '0) || (pop && (count_o == CNT_W'(1)))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_valid_d = (state_d == PLAY);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      done_q      <= done_d;
    end
  end

  // PLAY is only ever occupied with a non-empty buffer, so valid tracks the state.
  assign req_valid_o = req_valid_q;
  assign req_addr_o  = req_valid_q ? head_addr : '0;
  assign req_kind_o  = req_valid_q ? head_kind : KIND_INSTR;
  assign done_o      = done_q;

endmodule

// File: tb/tb_trace_replayer.sv
// Self-checking bench for trace_replayer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_trace_replayer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_DONE = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   load_valid_i;
  logic [ADDR_W-1:0]      load_addr_i;
  logic                   load_kind_i;
  logic                   load_ready_o;
  logic                   start_i;
  logic                   req_valid_o;
  logic [ADDR_W-1:0]      req_addr_o;
  logic                   req_kind_o;
  logic                   req_ready_i;
  logic                   done_o;
  logic [$clog2(DEPTH):0] count_o;

  always #5 clk_i = ~clk_i;

  trace_replayer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_valid_i (load_valid_i),
    .load_addr_i  (load_addr_i),
    .load_kind_i  (load_kind_i),
    .load_ready_o (load_ready_o),
    .start_i      (start_i),
    .req_valid_o  (req_valid_o),
    .req_addr_o   (req_addr_o),
    .req_kind_o   (req_kind_o),
    .req_ready_i  (req_ready_i),
    .done_o       (done_o),
    .count_o      (count_o)
  );

  int checks = 0;
  int passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct packed {
    logic        kind;
    logic [31:0] addr;
  } entry_t;

  entry_t model_q[$];
  int     model_mode = M_IDLE;
  int     cyc = 0;
  bit     chk_en = 1'b0;

  logic [31:0] log_addr[$];
  int          log_cyc[$];
  bit          done_seen = 1'b0;
  int          done_cyc = 0;

  always @(posedge clk_i) cyc++;

  // Reference model: a plain queue plus the three replay phases.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      model_q.delete();
      model_mode = M_IDLE;
    end else begin
      case (model_mode)
        M_IDLE: begin
          if (load_valid_i && model_q.size() < DEPTH) begin
            model_q.push_back({load_kind_i, load_addr_i});
          end
          if (start_i) begin
            model_mode = (model_q.size() > 0) ? M_PLAY : M_DONE;
          end
        end
        M_PLAY: begin
          if (req_ready_i && model_q.size() > 0) begin
            void'(model_q.pop_front());
          end
          if (model_q.size() == 0) begin
            model_mode = M_DONE;
          end
        end
        default: begin
          if (!start_i) begin
            model_mode = M_IDLE;
          end
        end
      endcase
    end
  end

  // Compare process and handshake/done logging, on the falling edge.
  always @(negedge clk_i) begin
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_kind;
    if (chk_en) begin
      exp_valid = (model_mode == M_PLAY) && (model_q.size() > 0);
      exp_addr  = exp_valid ? model_q[0].addr : 32'h0;
      exp_kind  = exp_valid ? model_q[0].kind : 1'b0;
      checkOutput("load_ready", load_ready_o, (model_mode == M_IDLE) && (model_q.size() < DEPTH));
      checkOutput("req_valid", req_valid_o, exp_valid);
      checkOutput("req_addr", req_addr_o, exp_addr);
      checkOutput("req_kind", req_kind_o, exp_kind);
      checkOutput("done", done_o, model_mode == M_DONE);
      checkOutput("count", count_o, model_q.size());
    end
    if (req_valid_o && req_ready_i) begin
      log_addr.push_back(req_addr_o);
      log_cyc.push_back(cyc);
    end
    if (done_o && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic applyStimulus(input logic lv, input logic [31:0] a, input logic k,
                               input logic st, input logic rdy);
    @(posedge clk_i);
    #1;
    load_valid_i = lv;
    load_addr_i  = a;
    load_kind_i  = k;
    start_i      = st;
    req_ready_i  = rdy;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic replayUntilDone(input bit random_ready);
    done_seen = 1'b0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, random_ready ? 1'($urandom % 2) : 1'b1);
    end
    if (!done_seen) checkOutput("replay_timeout", 32'd0, 32'd1);
    idleCycles(2);
  endtask

  logic [31:0] addrs[$];

  initial begin
    rst_i        = 1'b1;
    load_valid_i = 1'b0;
    load_addr_i  = '0;
    load_kind_i  = 1'b0;
    start_i      = 1'b0;
    req_ready_i  = 1'b0;
    #1 rst_i = 1'b0;
    #1 chk_en = 1'b1;
    checkOutput("rst_count", count_o, 32'd0);
    checkOutput("rst_req_valid", req_valid_o, 32'd0);
    checkOutput("rst_done", done_o, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 checkOutput("load_ready_after_reset", load_ready_o, 32'd1);

    // Three instruction fetches replayed back-to-back.
    log_addr.delete(); log_cyc.delete();
    applyStimulus(1'b1, 32'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h04, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h08, 1'b0, 1'b0, 1'b1);
    replayUntilDone(1'b0);
    checkOutput("seq3_len", log_addr.size(), 32'd3);
    if (log_addr.size() == 3) begin
      checkOutput("seq3_a0", log_addr[0], 32'h00);
      checkOutput("seq3_a1", log_addr[1], 32'h04);
      checkOutput("seq3_a2", log_addr[2], 32'h08);
      checkOutput("seq3_consec1", log_cyc[1], log_cyc[0] + 1);
      checkOutput("seq3_consec2", log_cyc[2], log_cyc[1] + 1);
      checkOutput("seq3_done_next", done_cyc, log_cyc[2] + 1);
    end

    // Fill to capacity, then offer one more that must be dropped.
    addrs.delete();
    for (int i = 0; i < DEPTH; i++) begin
      addrs.push_back({$urandom} & 32'hFFFF_FFF0);
      applyStimulus(1'b1, addrs[i], 1'($urandom % 2), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0);
    checkOutput("full_count", count_o, 32'd16);
    checkOutput("full_load_ready", load_ready_o, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("full_count_after_extra", count_o, 32'd16);
    log_addr.delete(); log_cyc.delete();
    replayUntilDone(1'b1);
    checkOutput("full_len", log_addr.size(), 32'd16);
    for (int i = 0; i < DEPTH && i < log_addr.size(); i++) begin
      checkOutput("full_order", log_addr[i], addrs[i]);
    end

    // Stall on the data access at 0x1C for five cycles.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h1C, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    log_addr.delete(); log_cyc.delete();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      checkOutput("stall_addr", req_addr_o, 32'h1C);
      checkOutput("stall_kind", req_kind_o, 32'd1);
      checkOutput("stall_valid", req_valid_o, 32'd1);
    end
    replayUntilDone(1'b0);
    checkOutput("stall_len", log_addr.size(), 32'd5);
    if (log_addr.size() == 5) begin
      checkOutput("stall_o3", log_addr[3], 32'h1C);
      checkOutput("stall_o4", log_addr[4], 32'h20);
    end

    // Start with an empty buffer.
    log_addr.delete(); log_cyc.delete();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("empty_done", done_o, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("empty_back_idle", done_o, 32'd0);
    checkOutput("empty_no_req", log_addr.size(), 32'd0);

    // Asynchronous reset after two of six pops.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h100 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("prerst_count", count_o, 32'd4);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("arst_valid", req_valid_o, 32'd0);
    checkOutput("arst_addr", req_addr_o, 32'd0);
    checkOutput("arst_kind", req_kind_o, 32'd0);
    checkOutput("arst_count", count_o, 32'd0);
    checkOutput("arst_done", done_o, 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    log_addr.delete(); log_cyc.delete();
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("arst_no_req", log_addr.size(), 32'd0);
    idleCycles(2);

    // Two passes of twelve with random load gaps; pointers wrap.
    for (int pass = 0; pass < 2; pass++) begin
      addrs.delete();
      while (addrs.size() < 12) begin
        if ($urandom % 3 != 0) begin
          addrs.push_back({$urandom} & 32'hFFFF_FFFC);
          applyStimulus(1'b1, addrs[addrs.size() - 1], 1'($urandom % 2), 1'b0, 1'b0);
        end else begin
          applyStimulus(1'b0, {$urandom}, 1'b0, 1'b0, 1'b0);
        end
      end
      log_addr.delete(); log_cyc.delete();
      replayUntilDone(1'b1);
      checkOutput("wrap_len", log_addr.size(), 32'd12);
      for (int i = 0; i < 12 && i < log_addr.size(); i++) begin
        checkOutput("wrap_order", log_addr[i], addrs[i]);
      end
    end

    // Unconstrained random traffic checked purely by the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom % 2), {$urandom}, 1'($urandom % 2),
                    ($urandom % 6) == 0, 1'($urandom % 2));
    end
    idleCycles(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
